// File: rtl/bus_rr_scheduler.sv
// Round-robin packet bus scheduler: polls device FIFOs, pops one packet per grant
// and pushes it to the destination device (or every other device on broadcast).
module bus_rr_scheduler #(
    parameter int          drvrs     = 4,
    parameter int          pckg_sz   = 16,
    parameter logic [7:0]  broadcast = 8'hFF
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [drvrs-1:0]                pndng,
    input  logic [drvrs-1:0][pckg_sz-1:0]   D_pop,
    output logic [drvrs-1:0]                pop,
    output logic [drvrs-1:0]                push,
    output logic [pckg_sz-1:0]              D_push,
    output logic                            busy,
    output logic [3:0]                      grant_id,
    output logic [7:0]                      err_cnt,
    output logic [15:0]                     pkt_cnt
);

    localparam int         GW   = (drvrs > 1) ? $clog2(drvrs) : 1;
    localparam logic [7:0] NDRV = 8'(drvrs);

    typedef enum logic [1:0] {IDLE, POP, PUSH} state_t;

    state_t               state_q, state_d;
    logic [drvrs-1:0]     pop_q, pop_d;
    logic [drvrs-1:0]     push_q, push_d;
    logic [pckg_sz-1:0]   D_push_q, D_push_d;
    logic                 busy_q, busy_d;
    logic [3:0]           grant_id_q, grant_id_d;
    logic [3:0]           last_q, last_d;
    logic [7:0]           err_cnt_q, err_cnt_d;
    logic [15:0]          pkt_cnt_q, pkt_cnt_d;

    logic                 sel_found;
    logic [3:0]           sel_idx;
    logic [GW-1:0]        idx_w;
    logic [GW-1:0]        gsel;
    logic [7:0]           hdr;

    // First pending requester at or after last+1, wrapping around.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        idx_w     = '0;
        for (int i = 0; i < drvrs; i++) begin
            idx_w = GW'((int'(last_q) + 1 + i) % drvrs);
            if (!sel_found && pndng[idx_w]) begin
                sel_found = 1'b1;
                sel_idx   = 4'(idx_w);
            end
        end
    end

    assign gsel = grant_id_q[GW-1:0];
    assign hdr  = D_pop[gsel][pckg_sz-1 -: 8];

    always_comb begin
        state_d    = state_q;
        pop_d      = '0;
        push_d     = '0;
        D_push_d   = D_push_q;
        grant_id_d = grant_id_q;
        last_d     = last_q;
        err_cnt_d  = err_cnt_q;
        pkt_cnt_d  = pkt_cnt_q;
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    grant_id_d                 = sel_idx;
                    last_d                     = sel_idx;
                    pop_d[sel_idx[GW-1:0]]     = 1'b1;
                    state_d                    = POP;
                end
            end
            POP: begin
                // Destination is decoded as the packet is latched so push is registered.
                D_push_d = D_pop[gsel];
                if (hdr == broadcast) begin
                    push_d       = '1;
                    push_d[gsel] = 1'b0;
                end else if (hdr < NDRV && hdr != {4'b0, grant_id_q}) begin
                    push_d[hdr[GW-1:0]] = 1'b1;
                end
                state_d = PUSH;
            end
            PUSH: begin
                if (|push_q)
                    pkt_cnt_d = pkt_cnt_q + 16'd1;
                else if (err_cnt_q != 8'hFF)
                    err_cnt_d = err_cnt_q + 8'd1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            pop_q      <= '0;
            push_q     <= '0;
            D_push_q   <= '0;
            busy_q     <= 1'b0;
            grant_id_q <= '0;
            last_q     <= 4'(drvrs - 1);
            err_cnt_q  <= '0;
            pkt_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            pop_q      <= pop_d;
            push_q     <= push_d;
            D_push_q   <= D_push_d;
            busy_q     <= busy_d;
            grant_id_q <= grant_id_d;
            last_q     <= last_d;
            err_cnt_q  <= err_cnt_d;
            pkt_cnt_q  <= pkt_cnt_d;
        end
    end

    assign pop      = pop_q;
    assign push     = push_q;
    assign D_push   = D_push_q;
    assign busy     = busy_q;
    assign grant_id = grant_id_q;
    assign err_cnt  = err_cnt_q;
    assign pkt_cnt  = pkt_cnt_q;

endmodule

// File: tb/tb_bus_rr_scheduler.sv
// Directed bench for bus_rr_scheduler: reset, unicast, round-robin, broadcast,
// drop/saturation, mid-packet reset and late-request scenarios.
module tb_bus_rr_scheduler;

    logic              clk;
    logic              reset;
    logic [3:0]        pndng;
    logic [3:0][15:0]  dpop;
    logic [3:0]        pop;
    logic [3:0]        push;
    logic [15:0]       D_push;
    logic              busy;
    logic [3:0]        grant_id;
    logic [7:0]        err_cnt;
    logic [15:0]       pkt_cnt;

    int n_cmp = 0;
    int n_err = 0;

    bus_rr_scheduler #(.drvrs(4), .pckg_sz(16), .broadcast(8'hFF)) dut (
        .clk      (clk),
        .reset    (reset),
        .pndng    (pndng),
        .D_pop    (dpop),
        .pop      (pop),
        .push     (push),
        .D_push   (D_push),
        .busy     (busy),
        .grant_id (grant_id),
        .err_cnt  (err_cnt),
        .pkt_cnt  (pkt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".pop"},   32'(pop),      0);
        chk({tag, ".push"},  32'(push),     0);
        chk({tag, ".busy"},  32'(busy),     0);
        chk({tag, ".dpush"}, 32'(D_push),   0);
        chk({tag, ".grant"}, 32'(grant_id), 0);
        chk({tag, ".err"},   32'(err_cnt),  0);
        chk({tag, ".pkt"},   32'(pkt_cnt),  0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        pndng = '0;
        dpop  = '0;
        tick();
        chk_all_zero("rst");
        reset = 1'b1;

        // Single packet from device 1 to device 2
        pndng   = 4'b0010;
        dpop[1] = 16'h0203;
        tick();
        chk("s.pop",   32'(pop),      32'h2);
        chk("s.grant", 32'(grant_id), 32'h1);
        chk("s.busy",  32'(busy),     32'h1);
        chk("s.push0", 32'(push),     32'h0);
        pndng = '0;
        tick();
        chk("s.push",  32'(push),     32'h4);
        chk("s.dpush", 32'(D_push),   32'h0203);
        chk("s.popx",  32'(pop),      32'h0);
        tick();
        chk("s.pkt",   32'(pkt_cnt),  32'h1);
        chk("s.busy3", 32'(busy),     32'h0);
        chk("s.pushx", 32'(push),     32'h0);

        // Round-robin with every device pending, each addressing its neighbour
        do_reset();
        for (int i = 0; i < 4; i++) dpop[i] = {8'((i + 1) % 4), 8'(8'h30 + i)};
        pndng = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("rr.pop",   32'(pop),      32'(1 << (k % 4)));
            chk("rr.grant", 32'(grant_id), 32'(k % 4));
            tick();
            chk("rr.popx",  32'(pop),      32'h0);
            chk("rr.push",  32'(push),     32'(1 << ((k + 1) % 4)));
            tick();
            chk("rr.idle",  32'(busy),     32'h0);
            chk("rr.pop0",  32'(pop),      32'h0);
        end
        pndng = '0;
        chk("rr.pkt", 32'(pkt_cnt), 32'd8);

        // Broadcast from device 2
        pndng   = 4'b0100;
        dpop[2] = 16'hFF55;
        tick();
        chk("bc.pop",   32'(pop),    32'h4);
        pndng = '0;
        tick();
        chk("bc.push",  32'(push),   32'hB);
        chk("bc.dpush", 32'(D_push), 32'hFF55);
        tick();
        chk("bc.pkt",   32'(pkt_cnt), 32'd9);

        // Drops: self-addressed, then out of range
        pndng   = 4'b0001;
        dpop[0] = 16'h0011;
        tick();
        chk("d1.pop",  32'(pop),  32'h1);
        tick();
        chk("d1.push", 32'(push), 32'h0);
        dpop[0] = 16'h0922;
        tick();
        chk("d1.err",  32'(err_cnt), 32'd1);
        tick();
        chk("d2.pop",  32'(pop),  32'h1);
        tick();
        chk("d2.push", 32'(push), 32'h0);
        tick();
        chk("d2.err",  32'(err_cnt), 32'd2);
        chk("d2.pkt",  32'(pkt_cnt), 32'd9);
        for (int k = 0; k < 300; k++) begin
            tick();
            tick();
            tick();
        end
        pndng = '0;
        chk("sat.err", 32'(err_cnt), 32'd255);
        chk("sat.pkt", 32'(pkt_cnt), 32'd9);
        tick();
        chk("sat.busy", 32'(busy), 32'h0);

        // Reset asserted during POP
        pndng   = 4'b0010;
        dpop[1] = 16'h0203;
        tick();
        chk("mr.pop", 32'(pop), 32'h2);
        reset = 1'b0;
        #1;
        chk_all_zero("mr");
        pndng   = 4'b1000;
        dpop[3] = 16'h0177;
        tick();
        chk("mr.nopush", 32'(push), 32'h0);
        reset = 1'b1;
        tick();
        chk("mr.pop3",   32'(pop),      32'h8);
        chk("mr.grant3", 32'(grant_id), 32'h3);
        pndng = '0;
        tick();
        chk("mr.push",  32'(push),   32'h2);
        chk("mr.dpush", 32'(D_push), 32'h0177);
        tick();
        chk("mr.pkt",   32'(pkt_cnt), 32'd1);

        // After reset, device 0 wins when all are pending
        do_reset();
        pndng = 4'b1111;
        tick();
        chk("fav.grant", 32'(grant_id), 32'h0);
        chk("fav.pop",   32'(pop),      32'h1);
        pndng = '0;

        // Late request from device 0 while device 3's packet is pushing
        do_reset();
        pndng   = 4'b1000;
        dpop[3] = 16'h0155;
        tick();
        chk("lr.pop3", 32'(pop), 32'h8);
        pndng = '0;
        tick();
        chk("lr.push", 32'(push), 32'h2);
        pndng   = 4'b0001;
        dpop[0] = 16'h0266;
        chk("lr.grant_push", 32'(grant_id), 32'h3);
        tick();
        chk("lr.grant_idle", 32'(grant_id), 32'h3);
        chk("lr.idle_pop",   32'(pop),      32'h0);
        chk("lr.busy",       32'(busy),     32'h0);
        tick();
        chk("lr.pop0",  32'(pop),      32'h1);
        chk("lr.grant0", 32'(grant_id), 32'h0);
        pndng = '0;
        tick();
        chk("lr.push0", 32'(push), 32'h4);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bus_rr_scheduler.md
# bus_rr_scheduler

Round-robin scheduler that shares one packet bus among `drvrs` device FIFOs. It polls each device's `pndng` flag, grants one requester at a time, and pops one packet from that requester. It decodes the destination ID in the packet header and pushes the packet into the destination device, or into every other device for a broadcast. It is the sequencing core of the bus generator/arbiter datapath, and the driver/checker testbench environment drives it.

## Interface
- `drvrs`, 4: number of devices on the bus (2..16).
- `pckg_sz`, 16: packet width in bits; bits `[pckg_sz-1:pckg_sz-8]` are the destination ID, the rest is payload.
- `broadcast`, 8'hFF: ID value meaning "deliver to all devices except the source".
- `clk` input 1: single clock; all logic is rising-edge.
- `reset` input 1: asynchronous, active-low reset.
- `pndng` input `drvrs`: bit i high = device i's FIFO holds at least one packet.
- `D_pop` input `drvrs x pckg_sz`: head-of-FIFO data of each device; valid whenever its `pndng` is high (first-word fall-through).
- `pop` output `drvrs`: one-hot, one-cycle pop strobe to the granted device.
- `push` output `drvrs`: one-cycle push strobes into destination device(s).
- `D_push` output `pckg_sz`: packet being delivered; shared by all devices and valid while any `push` bit is high.
- `busy` output 1: high in every state except IDLE.
- `grant_id` output 4: index of the device currently or last granted.
- `err_cnt` output 8: number of dropped packets; saturates at 255.
- `pkt_cnt` output 16: number of delivered packets; wraps modulo 2^16.

## Operation
- FSM states are IDLE, POP and PUSH; every output is registered.
- **IDLE:**
  - If `pndng` is 0, the FSM stays in IDLE.
  - Otherwise it selects the first set `pndng` bit, scanning upward from `(last+1) mod drvrs` with wrap-around.
  - It stores the selected index in `grant_id`/`last` and moves to POP.
- **POP:**
  - `pop[grant_id]` = 1 for exactly this cycle.
  - `D_pop[grant_id]` is latched into the packet register at the end of the cycle.
  - The FSM moves to PUSH.
- **PUSH:** decode `id` from the latched packet header. Exactly one of these cases applies:
  - `id == broadcast`: `push` = all ones except bit `grant_id`; `pkt_cnt` += 1.
  - `id < drvrs` and `id != grant_id`: `push` = one-hot(`id`); `pkt_cnt` += 1.
  - Otherwise (out-of-range ID or self-addressed): `push` = 0; the packet is dropped; `err_cnt` += 1 (saturating).
- After PUSH, the FSM returns to IDLE.
- `D_push` holds the latched packet from PUSH until the next packet is latched.
- Changes to `pndng` during POP or PUSH are ignored; arbitration occurs only in IDLE.
- The grant is never preempted; one packet per grant.
- A device never receives its own broadcast.

## Timing
- **Reset (asynchronous, `reset` = 0):**
  - state = IDLE; `pop`, `push`, `busy`, `D_push`, `grant_id`, `err_cnt` and `pkt_cnt` are all 0.
  - `last` = `drvrs-1`, so device 0 wins first.
- **Reset asserted mid-packet:**
  - Outputs clear immediately (asynchronously).
  - A packet already popped is lost and is not counted.
  - The FSM restarts in IDLE on the first edge after deassertion.
- **Latency:**
  - `pndng` sampled high at edge n.
  - `pop` is high during cycle n+1.
  - `push`/`D_push` are high during cycle n+2.
  - The FSM is back in IDLE at n+3.
  - Throughput is one packet per 3 cycles with back-to-back requests.
- **Fairness:** with all `pndng` bits high continuously, grants go 0,1,2,3,0,… Any requester waits at most `drvrs-1` packets.
- **Exclusivity:** `pop` and `push` are never high in the same cycle. At most one `pop` bit is high.
- **Counter update:** `err_cnt`/`pkt_cnt` update on the edge that leaves PUSH.

## Test plan
- **Reset then single packet:** after reset, `pndng`=4'b0010, `D_pop[1]`=16'h0203. Required response: `pop`=4'b0010 one cycle, then `push`=4'b0100 with `D_push`=16'h0203, `pkt_cnt`=1, `busy` low at cycle 3.
- **Round-robin:** all `pndng` held high with valid unicast IDs for 8 packets. Required response: `grant_id` sequence 0,1,2,3,0,1,2,3; exactly one `pop` per 3 cycles.
- **Broadcast:** device 2 sends 16'hFF55. Required response: `push`=4'b1011, `D_push`=16'hFF55, `pkt_cnt` += 1.
- **Drops:** device 0 sends ID 0 (self), then ID 9 (out of range). Required response: `push` stays 0 for both, `err_cnt`=2, `pkt_cnt` unchanged. Also force 300 drops. Required response: `err_cnt` stays at 255.
- **Reset mid-operation:** assert `reset` during POP. Required response: all outputs go to 0 immediately, and no `push` occurs for that packet. After release with `pndng`=4'b1000, device 3 is popped first if it alone is pending, and device 0 is favoured if all are pending.
- **Late request:** `pndng[0]` rises while in PUSH of device 3's packet. Required response: device 0 is granted in the following IDLE, and no grant changes mid-transfer.
